kf8259_inta_sequencer: RTL
==========================

# kf8259_inta_sequencer

CPU-side interrupt acknowledge sequencer that sits directly downstream of the KF8259 interrupt controller. It watches the controller's INT output, issues the two 8086-style INTA# pulses, and samples the vector byte the controller drives during the second pulse. It then hands that vector to the CPU core over a valid/ready handshake. It runs on the same clock as the controller.

## Interface
- PULSE_WIDTH, 4, clocks INTA# is held low per pulse (≥1)
- GAP_WIDTH, 2, clocks INTA# is held high between pulses (≥1)
- TIMEOUT_CYCLES, 16, DELIVER watchdog limit; only used when KF8259_INTA_TIMEOUT_EN is defined (≥1)

- clock  in  1  system clock, rising-edge
- reset_n  in  1  asynchronous, active-low reset
- interrupt_to_cpu  in  1  INT from the controller
- interrupt_enable  in  1  CPU interrupt-enable flag
- data_bus_in  in  8  controller data_bus_out
- data_bus_io  in  1  controller bus direction; 0 = controller driving
- interrupt_acknowledge_n  out  1  INTA# to the controller, registered
- vector  out  8  captured vector byte
- vector_error  out  1  controller was not driving at the sample point; qualified by vector_valid
- vector_valid  out  1  vector available to the CPU
- vector_ready  in  1  CPU accepts the vector
- busy  out  1  high in every state except IDLE
- timeout  out  1  one-cycle pulse on watchdog expiry; tied 0 without the macro

## Operation
- FSM states: IDLE, ACK1, GAP, ACK2, DELIVER. A single down-counter times ACK1, GAP, ACK2 and the watchdog.
- IDLE → ACK1 when interrupt_to_cpu && interrupt_enable on a rising edge. The counter loads PULSE_WIDTH-1.
- ACK1: INTA#=0. When the counter reaches 0, go to GAP and load GAP_WIDTH-1.
- GAP: INTA#=1. When the counter reaches 0, go to ACK2 and load PULSE_WIDTH-1.
- ACK2: INTA#=0. On the last ACK2 cycle (counter 0), register the vector and go to DELIVER:
  - if data_bus_io==0: vector←data_bus_in, vector_error←0
  - otherwise: vector←8'hFF, vector_error←1
- DELIVER: vector_valid=1. vector and vector_error are held stable until the handshake. On vector_valid && vector_ready, go to IDLE.
- Once ACK1 is entered the sequence is committed. Deasserting interrupt_to_cpu or interrupt_enable mid-sequence does not abort it; the controller supplies its own spurious vector.
- Every output is driven from a register or decoded directly from state.
- Reset values:
  - INTA#=1, vector=8'h00, vector_error=0, vector_valid=0
  - busy=0, timeout=0, state=IDLE, counter=0
- reset_n asserted at any point, including mid-pulse, forces all reset values immediately (asynchronous). No partial pulse completes.
- Counter width is $clog2 of max(PULSE_WIDTH, GAP_WIDTH, TIMEOUT_CYCLES), plus 1 bit. The counter never wraps: each load happens only at 0.

## Timing
- Request sampled at edge E0:
  - ACK1 occupies cycles 1..PW
  - GAP occupies PW+1..PW+GW
  - ACK2 occupies PW+GW+1..2PW+GW
  - vector_valid rises in cycle 2PW+GW+1 (11 with the defaults)
- vector_ready already high when vector_valid rises: accept in that same cycle; IDLE follows in the next cycle.
- Back-to-back: after acceptance, IDLE lasts at least 1 cycle before ACK1 can start again.
- busy is high from cycle 1 through the acceptance cycle.

## Configuration
- KF8259_INTA_TIMEOUT_EN defined:
  - entering DELIVER loads TIMEOUT_CYCLES-1
  - if the counter reaches 0 without a handshake: drop vector_valid, pulse timeout for 1 cycle, return to IDLE
- Undefined: DELIVER waits indefinitely, timeout is constant 0, and no watchdog logic is built.

## Structure
- Package kf8259_inta_pkg holds:
  - the state enum typedef
  - the localparam INTA_SPURIOUS_VECTOR = 8'hFF
- Natural sub-module: kf8259_inta_pulse_timer (loadable down-counter with a zero flag). The FSM stays in the top module.

## Test plan
- PW=4, GW=2, INT=1, IE=1, controller drives 0x20 with data_bus_io=0 → INTA# low in cycles 1–4 and 7–10; vector_valid in cycle 11 with vector=0x20, vector_error=0.
- Hold vector_ready=0 for 5 cycles after valid, then 1 → vector stays 0x20 throughout; vector_valid drops the cycle after the handshake; busy falls with it.
- INT=1, IE=0 for 10 cycles, then IE=1 → INTA# stays 1 and busy stays 0 while IE=0; ACK1 starts the cycle after the IE=1 edge sample.
- data_bus_io=1 at the last ACK2 cycle → vector=0xFF, vector_error=1.
- Assert reset_n=0 in GAP cycle 5, release after 3 cycles with INT=1 → INTA#=1 and all outputs at reset values immediately; a fresh sequence then starts with a full 4-cycle ACK1.
- With the macro, TIMEOUT_CYCLES=8 and vector_ready=0 → timeout pulses in DELIVER cycle 8; vector_valid drops with it; next state is IDLE.

Source files
------------

// File: rtl/kf8259_inta_pkg.sv
// Shared types and constants for the KF8259 interrupt-acknowledge sequencer.
package kf8259_inta_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACK1    = 3'd1,
    GAP     = 3'd2,
    ACK2    = 3'd3,
    DELIVER = 3'd4
  } inta_state_t;

  localparam logic [7:0] INTA_SPURIOUS_VECTOR = 8'hFF;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/kf8259_inta_pulse_timer.sv
// Loadable down-counter that saturates at zero and flags when it is there.
module kf8259_inta_pulse_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count_r;

  // Count register: load wins, otherwise decrement until zero and hold there.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != '0) begin
      count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/kf8259_inta_sequencer.sv
// Two-pulse INTA# sequencer: samples the KF8259 vector and hands it to the CPU.
// Optional DELIVER watchdog enabled by defining KF8259_INTA_TIMEOUT_EN.
module kf8259_inta_sequencer
  import kf8259_inta_pkg::*;
#(
  parameter int PULSE_WIDTH    = 4,
  parameter int GAP_WIDTH      = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       interrupt_to_cpu,
  input  logic       interrupt_enable,
  input  logic [7:0] data_bus_in,
  input  logic       data_bus_io,
  output logic       interrupt_acknowledge_n,
  output logic [7:0] vector,
  output logic       vector_error,
  output logic       vector_valid,
  input  logic       vector_ready,
  output logic       busy,
  output logic       timeout
);

  localparam int CNT_W = $clog2(max3(PULSE_WIDTH, GAP_WIDTH, TIMEOUT_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] PW_LOAD = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] GW_LOAD = CNT_W'(GAP_WIDTH - 1);

  inta_state_t      state_r, next_state_s;
  logic             load_s;
  logic [CNT_W-1:0] load_value_s;
  logic             capture_s;
  logic             cnt_zero_s;
  logic             inta_n_r;
  logic [7:0]       vector_r;
  logic             vector_error_r;

`ifdef KF8259_INTA_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  logic timeout_set_s;
  logic timeout_r;
`endif

  kf8259_inta_pulse_timer #(.WIDTH(CNT_W)) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (load_s),
    .load_value (load_value_s),
    .zero       (cnt_zero_s)
  );

  // Next-state and timer-load decode; once ACK1 starts the sequence runs to DELIVER.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    load_value_s = '0;
    capture_s    = 1'b0;
`ifdef KF8259_INTA_TIMEOUT_EN
    timeout_set_s = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (interrupt_to_cpu && interrupt_enable) begin
          next_state_s = ACK1;
          load_s       = 1'b1;
          load_value_s = PW_LOAD;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACK1: begin
        if (cnt_zero_s) begin
          next_state_s = GAP;
          load_s       = 1'b1;
          load_value_s = GW_LOAD;
        end else begin
          next_state_s = ACK1;
        end
      end
      GAP: begin
        if (cnt_zero_s) begin
          next_state_s = ACK2;
          load_s       = 1'b1;
          load_value_s = PW_LOAD;
        end else begin
          next_state_s = GAP;
        end
      end
      ACK2: begin
        if (cnt_zero_s) begin
          next_state_s = DELIVER;
          capture_s    = 1'b1;
`ifdef KF8259_INTA_TIMEOUT_EN
          load_s       = 1'b1;
          load_value_s = TO_LOAD;
`endif
        end else begin
          next_state_s = ACK2;
        end
      end
      DELIVER: begin
        if (vector_ready) begin
          next_state_s = IDLE;
        end
`ifdef KF8259_INTA_TIMEOUT_EN
        else if (cnt_zero_s) begin
          next_state_s  = IDLE;
          timeout_set_s = 1'b1;
        end
`endif
        else begin
          next_state_s = DELIVER;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, INTA# and captured vector registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      inta_n_r       <= 1'b1;
      vector_r       <= 8'h00;
      vector_error_r <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      // INTA# follows the state being entered so it is low exactly in ACK1/ACK2.
      inta_n_r <= !((next_state_s == ACK1) || (next_state_s == ACK2));
      if (capture_s) begin
        if (!data_bus_io) begin
          vector_r       <= data_bus_in;
          vector_error_r <= 1'b0;
        end else begin
          vector_r       <= INTA_SPURIOUS_VECTOR;
          vector_error_r <= 1'b1;
        end
      end else begin
        vector_r       <= vector_r;
        vector_error_r <= vector_error_r;
      end
    end
  end

`ifdef KF8259_INTA_TIMEOUT_EN
  // One-cycle watchdog pulse, coincident with vector_valid dropping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= timeout_set_s;
    end
  end
  assign timeout = timeout_r;
`else
  assign timeout = 1'b0;
`endif

  assign interrupt_acknowledge_n = inta_n_r;
  assign vector                  = vector_r;
  assign vector_error            = vector_error_r;
  assign vector_valid            = (state_r == DELIVER);
  assign busy                    = (state_r != IDLE);

endmodule
